fault_injector: RTL and testbench

- Synthesizable, parametrised fault-injection block for the fault-tolerant cores.
- Sits between the instruction/data buses and N_CH core channels, and corrupts selected beats under a pseudo-random schedule.
- Modes: bit-flip, stuck-at-0, stuck-at-1, or substitution from a programmable pattern table.
- Counts injections and detected errors, so campaigns run in RTL or on FPGA without testbench force statements.

---
 rtl/fault_injector.sv | 225 ++++++++++++++++++++++
 tb/tb_fault_injector.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fault_injector.sv
// Fault injector: corrupts selected channel beats on a pseudo-random schedule and counts
// injections and detected errors. Define FI_LATENCY_EN to add injection-to-detection latency outputs.
module fault_injector #(
   parameter int          N_CH     = 2,
   parameter int          DATA_W   = 32,
   parameter int          ADDR_W   = 32,
   parameter int          N_PAT    = 4,
   parameter int          CNT_W    = 8,
   parameter int          COOLDOWN = 16,
   parameter logic [31:0] SEED     = 32'hACE1_0001,
   localparam int         PAT_W    = (N_PAT > 1) ? $clog2(N_PAT) : 1
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     arm_i,
   input  logic                     clear_i,
   input  logic [1:0]               mode_i,
   input  logic [N_CH-1:0]          ch_mask_i,
   input  logic [7:0]               threshold_i,
   input  logic [CNT_W-1:0]         max_inj_i,
   input  logic [ADDR_W-1:0]        win_lo_i,
   input  logic [ADDR_W-1:0]        win_hi_i,
   input  logic                     pat_we_i,
   input  logic [PAT_W-1:0]         pat_idx_i,
   input  logic [DATA_W-1:0]        pat_data_i,
   input  logic [N_CH*ADDR_W-1:0]   addr_i,
   input  logic [N_CH*DATA_W-1:0]   data_i,
   output logic [N_CH*DATA_W-1:0]   data_o,
   input  logic                     error_i,
   output logic [N_CH-1:0]          inject_o,
   output logic [CNT_W-1:0]         inj_count_o,
   output logic [CNT_W-1:0]         det_count_o,
   output logic [1:0]               state_o
`ifdef FI_LATENCY_EN
   ,
   output logic [15:0]              lat_last_o,
   output logic [15:0]              lat_max_o
`endif
);

   localparam int          CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int          BIT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam int          CD_W     = $clog2(COOLDOWN + 1);
   localparam logic [31:0] TAPS     = 32'h8020_0003;
   localparam logic [31:0] SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_ARMED    = 2'd1,
      S_COOLDOWN = 2'd2,
      S_DONE     = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [31:0]         lfsr_q, lfsr_next;
   logic [CD_W-1:0]     cd_cnt_q;
   logic                cd_done;
   logic [CNT_W-1:0]    inj_cnt_q, det_cnt_q;
   logic                err_prev_q, err_rise;
   logic [DATA_W-1:0]   pat_q [N_PAT];

   logic [CH_W-1:0]     r_ch;
   logic [BIT_W-1:0]    r_bit;
   logic [PAT_W-1:0]    r_pat;
   logic [ADDR_W-1:0]   addr_sel;
   logic                in_window, hit, budget_spent;

   logic                inj_valid_q;
   logic [CH_W-1:0]     inj_ch_q;
   logic [BIT_W-1:0]    inj_bit_q;
   logic [PAT_W-1:0]    inj_pat_q;
   logic [1:0]          inj_mode_q;

   // Random fields drawn from disjoint slices of the current LFSR word.
   assign r_ch  = CH_W'({24'd0, lfsr_q[15:8]} % 32'(N_CH));
   assign r_bit = BIT_W'({16'd0, lfsr_q[31:16]} % 32'(DATA_W));
   assign r_pat = PAT_W'({30'd0, lfsr_q[1:0]} % 32'(N_PAT));

   assign lfsr_next = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? TAPS : 32'd0);

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      addr_sel = '0;
      for (int c = 0; c < N_CH; c++) begin
         if (r_ch == CH_W'(c)) addr_sel = addr_i[c*ADDR_W +: ADDR_W];
      end
   end

   assign in_window    = (addr_sel >= win_lo_i) && (addr_sel <= win_hi_i);
   assign hit          = (state_q == S_ARMED) && arm_i && (lfsr_q[7:0] < threshold_i)
                         && ch_mask_i[r_ch] && in_window;
   assign cd_done      = (cd_cnt_q == CD_W'(COOLDOWN - 1));
   assign budget_spent = (max_inj_i != '0) && (inj_cnt_q >= max_inj_i);
   assign err_rise     = error_i && !err_prev_q;

   always_comb begin
      state_d = state_q;
      if (!arm_i) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:     state_d = S_ARMED;
            S_ARMED:    if (hit) state_d = S_COOLDOWN;
            S_COOLDOWN: if (cd_done) state_d = budget_spent ? S_DONE : S_ARMED;
            S_DONE:     state_d = S_DONE;
            default:    state_d = S_IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         lfsr_q     <= SEED_EFF;
         cd_cnt_q   <= '0;
         err_prev_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         err_prev_q <= error_i;
         if (clear_i)                lfsr_q <= SEED_EFF;
         else if (state_q != S_IDLE) lfsr_q <= lfsr_next;
         if (state_q == S_COOLDOWN && !cd_done) cd_cnt_q <= cd_cnt_q + 1'b1;
         else                                   cd_cnt_q <= '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         inj_cnt_q <= '0;
         det_cnt_q <= '0;
      end else if (clear_i) begin
         inj_cnt_q <= '0;
         det_cnt_q <= '0;
      end else begin
         if (hit && inj_cnt_q != '1) inj_cnt_q <= inj_cnt_q + 1'b1;
         if (err_rise && state_q != S_IDLE && det_cnt_q != '1) det_cnt_q <= det_cnt_q + 1'b1;
      end
   end

   // Injection parameters are captured at the hit edge and applied for exactly one cycle.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         inj_valid_q <= 1'b0;
         inj_ch_q    <= '0;
         inj_bit_q   <= '0;
         inj_pat_q   <= '0;
         inj_mode_q  <= '0;
      end else begin
         inj_valid_q <= hit;
         if (hit) begin
            inj_ch_q   <= r_ch;
            inj_bit_q  <= r_bit;
            inj_pat_q  <= r_pat;
            inj_mode_q <= mode_i;
         end
      end
   end

   // NOTE: the pattern table is reset because campaigns rely on it reading zero until programmed.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < N_PAT; i++) pat_q[i] <= '0;
      end else if (pat_we_i) begin
         pat_q[pat_idx_i] <= pat_data_i;
      end
   end

   function automatic logic [DATA_W-1:0] corrupt(input logic [DATA_W-1:0] word);
      logic [DATA_W-1:0] mask;
      mask = DATA_W'(1) << inj_bit_q;
      case (inj_mode_q)
         2'd0:    corrupt = word ^ mask;
         2'd1:    corrupt = word & ~mask;
         2'd2:    corrupt = word | mask;
         default: corrupt = pat_q[inj_pat_q];
      endcase
   endfunction

   always_comb begin
      data_o   = data_i;
      inject_o = '0;
      for (int c = 0; c < N_CH; c++) begin
         if (inj_valid_q && inj_ch_q == CH_W'(c)) begin
            inject_o[c]                 = 1'b1;
            data_o[c*DATA_W +: DATA_W]  = corrupt(data_i[c*DATA_W +: DATA_W]);
         end
      end
   end

   assign inj_count_o = inj_cnt_q;
   assign det_count_o = det_cnt_q;
   assign state_o     = state_q;

`ifdef FI_LATENCY_EN
   logic [15:0] lat_cnt_q, lat_last_q, lat_max_q;
   logic        lat_run_q;

   // The counter reads 1 in the cycle after inject_o, so an error k cycles later records k.
   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         lat_cnt_q  <= '0;
         lat_last_q <= '0;
         lat_max_q  <= '0;
         lat_run_q  <= 1'b0;
      end else if (inj_valid_q && err_rise) begin
         lat_last_q <= '0;
         lat_run_q  <= 1'b0;
      end else if (inj_valid_q) begin
         lat_cnt_q <= 16'd1;
         lat_run_q <= 1'b1;
      end else if (lat_run_q && err_rise) begin
         lat_last_q <= lat_cnt_q;
         if (lat_cnt_q > lat_max_q) lat_max_q <= lat_cnt_q;
         lat_run_q <= 1'b0;
      end else if (lat_run_q && lat_cnt_q != 16'hFFFF) begin
         lat_cnt_q <= lat_cnt_q + 16'd1;
      end
   end

   assign lat_last_o = lat_last_q;
   assign lat_max_o  = lat_max_q;
`endif

endmodule

// File: tb/tb_fault_injector.sv
// Directed bench for fault_injector: reset, quiet configurations, each corruption mode,
// budget, address window, error detection and reset during an injection.
module tb_fault_injector;

   localparam int N_CH = 2, DATA_W = 32, ADDR_W = 32, N_PAT = 4, CNT_W = 8;

   logic                   clk_i = 1'b0;
   logic                   rst_i, arm_i, clear_i, pat_we_i, error_i;
   logic [1:0]             mode_i;
   logic [N_CH-1:0]        ch_mask_i;
   logic [7:0]             threshold_i;
   logic [CNT_W-1:0]       max_inj_i;
   logic [ADDR_W-1:0]      win_lo_i, win_hi_i;
   logic [1:0]             pat_idx_i;
   logic [DATA_W-1:0]      pat_data_i;
   logic [N_CH*ADDR_W-1:0] addr_i;
   logic [N_CH*DATA_W-1:0] data_i, data_o;
   logic [N_CH-1:0]        inject_o;
   logic [CNT_W-1:0]       inj_count_o, det_count_o;
   logic [1:0]             state_o;
`ifdef FI_LATENCY_EN
   logic [15:0]            lat_last_o, lat_max_o;
`endif

   fault_injector #(.N_CH(N_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_PAT(N_PAT),
                    .CNT_W(CNT_W), .COOLDOWN(16), .SEED(32'hACE1_0001)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .arm_i(arm_i), .clear_i(clear_i), .mode_i(mode_i),
      .ch_mask_i(ch_mask_i), .threshold_i(threshold_i), .max_inj_i(max_inj_i),
      .win_lo_i(win_lo_i), .win_hi_i(win_hi_i), .pat_we_i(pat_we_i), .pat_idx_i(pat_idx_i),
      .pat_data_i(pat_data_i), .addr_i(addr_i), .data_i(data_i), .data_o(data_o),
      .error_i(error_i), .inject_o(inject_o), .inj_count_o(inj_count_o),
      .det_count_o(det_count_o), .state_o(state_o)
`ifdef FI_LATENCY_EN
      , .lat_last_o(lat_last_o), .lat_max_o(lat_max_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   int          n_checks = 0, n_err = 0;
   int          n_inj, bad_sel, bad_data, bad_pass, bad_state, min_gap, max_gap, last_inj;
   logic [31:0] pats [4];
   bit          found;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic go_idle();
      arm_i = 1'b0;
      step();
      step();
   endtask

   task automatic pulse_clear();
      clear_i = 1'b1;
      step();
      clear_i = 1'b0;
   endtask

   function automatic bit word_ok(input logic [31:0] din, input logic [31:0] dout);
      int ones;
      ones = $countones(din ^ dout);
      case (mode_i)
         2'd0:    word_ok = (ones == 1);
         2'd1:    word_ok = (ones == 1) && ((dout & ~din) == 32'd0);
         2'd2:    word_ok = (ones == 1) && ((din & ~dout) == 32'd0);
         default: word_ok = (dout == pats[0]) || (dout == pats[1]) ||
                            (dout == pats[2]) || (dout == pats[3]);
      endcase
   endfunction

   // Steps n cycles collecting statistics on injections, corrupted words and pass-through.
   task automatic watch(input int n, input logic [1:0] allowed, input int exp_state);
      n_inj = 0; bad_sel = 0; bad_data = 0; bad_pass = 0; bad_state = 0;
      min_gap = 1_000_000; max_gap = 0; last_inj = -1;
      for (int k = 0; k < n; k++) begin
         step();
         if (exp_state >= 0 && state_o != 2'(exp_state)) bad_state++;
         if (inject_o != '0) begin
            n_inj++;
            if (!$onehot(inject_o) || (inject_o & ~allowed) != '0) bad_sel++;
            if (last_inj >= 0) begin
               if (k - last_inj < min_gap) min_gap = k - last_inj;
               if (k - last_inj > max_gap) max_gap = k - last_inj;
            end
            last_inj = k;
         end
         for (int c = 0; c < N_CH; c++) begin
            if (inject_o[c]) begin
               if (!word_ok(data_i[c*DATA_W +: DATA_W], data_o[c*DATA_W +: DATA_W])) bad_data++;
            end else if (data_o[c*DATA_W +: DATA_W] !== data_i[c*DATA_W +: DATA_W]) begin
               bad_pass++;
            end
         end
      end
   endtask

   task automatic wait_inject(output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 100; k++) begin
         step();
         if (inject_o != '0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      pats[0] = 32'h0000_0013; pats[1] = 32'h4015_5513;
      pats[2] = 32'hFEA0_48E3; pats[3] = 32'h02A5_0533;
      rst_i = 1'b1; arm_i = 1'b0; clear_i = 1'b0; pat_we_i = 1'b0; error_i = 1'b0;
      mode_i = 2'd0; ch_mask_i = 2'b11; threshold_i = 8'd0; max_inj_i = '0;
      win_lo_i = 32'h0; win_hi_i = 32'hFFFF_FFFF; pat_idx_i = '0; pat_data_i = '0;
      addr_i = {32'h0000_0010, 32'h0000_0010};
      data_i = {32'hCAFE_F00D, 32'h1234_5678};
      step();
      step();

      check("reset_state", state_o, 0);
      check("reset_inject", inject_o, 0);
      check("reset_data_pass", data_o, {32'hCAFE_F00D, 32'h1234_5678});
      rst_i = 1'b0;
      step();
      check("idle_inj_count", inj_count_o, 0);
      check("idle_det_count", det_count_o, 0);

      // Threshold zero never hits.
      arm_i = 1'b1;
      watch(1000, 2'b11, 1);
      check("thr0_no_inject", n_inj, 0);
      check("thr0_pass", bad_pass, 0);
      check("thr0_armed", bad_state, 0);
      check("thr0_count", inj_count_o, 0);

      // Empty channel mask never hits.
      threshold_i = 8'd255; ch_mask_i = 2'b00;
      watch(100, 2'b11, 1);
      check("mask0_no_inject", n_inj, 0);
      go_idle();

      // Flip on channel 1 only.
      ch_mask_i = 2'b10; arm_i = 1'b1;
      watch(300, 2'b10, -1);
      check("flip_ch1_some", n_inj >= 8, 1);
      check("flip_ch1_sel", bad_sel, 0);
      check("flip_ch1_onebit", bad_data, 0);
      check("flip_ch1_pass", bad_pass, 0);
      check("flip_ch1_gap", min_gap >= 17, 1);
      check("flip_ch1_count", inj_count_o, n_inj);
      go_idle();

      // Flip on both channels: back-to-back spacing is hit + 16 cooldown cycles.
      pulse_clear();
      ch_mask_i = 2'b11; arm_i = 1'b1;
      watch(300, 2'b11, -1);
      check("flip_both_gap_min", min_gap, 17);
      check("flip_both_onebit", bad_data, 0);
      check("flip_both_pass", bad_pass, 0);
      go_idle();

      // Stuck-at modes on saturated data so the targeted bit must change.
      mode_i = 2'd1; data_i = '1; arm_i = 1'b1;
      watch(120, 2'b11, -1);
      check("stuck0_some", n_inj >= 3, 1);
      check("stuck0_word", bad_data, 0);
      go_idle();
      mode_i = 2'd2; data_i = '0; arm_i = 1'b1;
      watch(120, 2'b11, -1);
      check("stuck1_some", n_inj >= 3, 1);
      check("stuck1_word", bad_data, 0);
      go_idle();

      // Substitution from the programmed table.
      for (int i = 0; i < 4; i++) begin
         pat_we_i = 1'b1; pat_idx_i = 2'(i); pat_data_i = pats[i];
         step();
      end
      pat_we_i = 1'b0;
      mode_i = 2'd3; data_i = {32'h5555_AAAA, 32'h0F0F_F0F0}; arm_i = 1'b1;
      watch(200, 2'b11, -1);
      check("subst_some", n_inj >= 5, 1);
      check("subst_in_table", bad_data, 0);
      check("subst_pass", bad_pass, 0);
      go_idle();

      // Injection budget of three ends in DONE.
      pulse_clear();
      check("clear_inj_count", inj_count_o, 0);
      mode_i = 2'd0; max_inj_i = 8'd3; arm_i = 1'b1;
      n_inj = 0;
      for (int k = 0; k < 400; k++) begin
         step();
         if (inject_o != '0) n_inj++;
         if (state_o == 2'd3) break;
      end
      check("budget_state_done", state_o, 3);
      check("budget_inj_count", inj_count_o, 3);
      check("budget_pulses", n_inj, 3);
      watch(50, 2'b11, 3);
      check("done_no_inject", n_inj, 0);
      check("done_holds", bad_state, 0);
      arm_i = 1'b0;
      step();
      check("disarm_idle", state_o, 0);
      check("disarm_count_hold", inj_count_o, 3);

      // Address window on channel 0.
      max_inj_i = '0;
      pulse_clear();
      ch_mask_i = 2'b01; win_lo_i = 32'h0; win_hi_i = 32'h0FF;
      addr_i = {32'h0000_0010, 32'h0000_0100}; arm_i = 1'b1;
      watch(150, 2'b01, 1);
      check("win_above_no_hit", n_inj, 0);
      check("win_above_armed", bad_state, 0);
      win_lo_i = 32'h200; win_hi_i = 32'h100; addr_i = {32'h0000_0180, 32'h0000_0180};
      watch(100, 2'b01, 1);
      check("win_empty_no_hit", n_inj, 0);
      win_lo_i = 32'h0; win_hi_i = 32'h0FF; addr_i = {32'h0000_0010, 32'h0000_00FC};
      watch(100, 2'b01, -1);
      check("win_inside_hits", n_inj >= 1, 1);
      check("win_inside_sel", bad_sel, 0);
      addr_i = {32'h0000_0010, 32'h0000_00FF};
      watch(100, 2'b01, -1);
      check("win_hi_inclusive", n_inj >= 1, 1);
      go_idle();

      // Error edge detection, idle masking, clear priority and saturation.
      threshold_i = 8'd0; arm_i = 1'b1;
      pulse_clear();
      for (int r = 0; r < 2; r++) begin
         error_i = 1'b1; repeat (5) step();
         error_i = 1'b0; repeat (3) step();
      end
      check("det_two_edges", det_count_o, 2);
      arm_i = 1'b0; step(); step();
      error_i = 1'b1; repeat (5) step();
      error_i = 1'b0; step();
      check("det_idle_ignored", det_count_o, 2);
      arm_i = 1'b1; step();
      error_i = 1'b1; clear_i = 1'b1;
      step();
      clear_i = 1'b0; error_i = 1'b0;
      check("det_clear_priority", det_count_o, 0);
      step();
      for (int r = 0; r < 260; r++) begin
         error_i = 1'b1; step();
         error_i = 1'b0; step();
      end
      check("det_saturate", det_count_o, 255);

      // Reset while an injection pulse is on the outputs.
      pulse_clear();
      threshold_i = 8'd255; ch_mask_i = 2'b11; win_hi_i = 32'hFFFF_FFFF;
      wait_inject(found);
      check("rst_found_inject", found, 1);
      rst_i = 1'b1;
      step();
      check("rst_inject_drop", inject_o, 0);
      check("rst_data_pass", data_o, data_i);
      check("rst_state_idle", state_o, 0);
      rst_i = 1'b0;

`ifdef FI_LATENCY_EN
      wait_inject(found);
      check("lat_found_first", found, 1);
      repeat (7) step();
      error_i = 1'b1; repeat (5) step();
      error_i = 1'b0; step();
      check("lat_last_7", lat_last_o, 7);
      check("lat_max_7", lat_max_o, 7);
      wait_inject(found);
      check("lat_found_second", found, 1);
      repeat (3) step();
      error_i = 1'b1; step();
      error_i = 1'b0;
      check("lat_last_3", lat_last_o, 3);
      check("lat_max_keeps_7", lat_max_o, 7);
      pulse_clear();
      check("lat_clear_last", lat_last_o, 0);
      check("lat_clear_max", lat_max_o, 0);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
